// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative write-back cache.
// The FLUSH encoding exists only when CACHE_FLUSH_EN is defined.
package cache_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned INDEX_W_DEF = 10;
    localparam int unsigned WAYS_DEF    = 2;
    localparam int unsigned TAG_W       = ADDR_W_DEF - INDEX_W_DEF;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWb,
`ifdef CACHE_FLUSH_EN
        StFill,
        StFlush
`else
        StFill
`endif
    } state_e;

endpackage

// File: rtl/cache_way.sv
// One cache way: tag/data arrays with a combinational read and synchronous write,
// plus per-set valid/dirty bits that are cleared by reset.
module cache_way
    import cache_pkg::*;
#(
    parameter int unsigned INDEX_W  = INDEX_W_DEF,
    parameter int unsigned TAG_BITS = TAG_W,
    parameter int unsigned DATA_W   = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  index,
    input  logic [TAG_BITS-1:0] cmp_tag,
    output logic [TAG_BITS-1:0] tag,
    output logic [DATA_W-1:0]   data,
    output logic                valid,
    output logic                dirty,
    output logic                hit,
    input  logic                we,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                wr_dirty
);

    localparam int unsigned SETS = 1 << INDEX_W;

    logic [TAG_BITS-1:0] tag_mem  [SETS];
    logic [DATA_W-1:0]   data_mem [SETS];
    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;

    always_ff @(posedge clk) begin
        if (we) begin
            tag_mem[index]  <= wr_tag;
            data_mem[index] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= wr_dirty;
        end
    end

    assign tag   = tag_mem[index];
    assign data  = data_mem[index];
    assign valid = valid_q[index];
    assign dirty = dirty_q[index];
    assign hit   = valid && (tag == cmp_tag);

endmodule

// File: rtl/assoc_wb_cache.sv
// Set-associative write-back, write-allocate cache with LRU replacement and a
// req/ack miss engine. Define CACHE_FLUSH_EN to add the flush_req/flush_done walk.
module assoc_wb_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned INDEX_W = INDEX_W_DEF,
    parameter int unsigned WAYS    = WAYS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef CACHE_FLUSH_EN
    input  logic              flush_req,
    output logic              flush_done,
`endif
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned TAG_BITS = ADDR_W - INDEX_W;
    localparam int unsigned SETS     = 1 << INDEX_W;

    state_e              state_q, state_d;
    logic                req_we_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic                victim_q, victim_d;
    logic [SETS-1:0]     lru_q;
    logic                resp_valid_q, resp_set;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic                accept, mru_en, mru_way, hit_way, alloc_way;

    logic [INDEX_W-1:0]  index;
    logic [TAG_BITS-1:0] req_tag;
    logic [TAG_BITS-1:0] way_tag  [WAYS];
    logic [DATA_W-1:0]   way_data [WAYS];
    logic [WAYS-1:0]     way_valid, way_dirty, way_hit, way_we;
    logic [TAG_BITS-1:0] wr_tag;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_dirty;

    assign req_tag = req_addr_q[ADDR_W-1:INDEX_W];

`ifdef CACHE_FLUSH_EN
    logic [INDEX_W-1:0] flush_set_q;
    logic               flush_way_q, flush_done_q, flush_step, flush_last;

    assign index      = (state_q == StFlush) ? flush_set_q : req_addr_q[INDEX_W-1:0];
    assign flush_last = (&flush_set_q) && (flush_way_q == 1'(WAYS - 1));
    assign flush_done = flush_done_q;
`else
    assign index = req_addr_q[INDEX_W-1:0];
`endif

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        cache_way #(
            .INDEX_W  (INDEX_W),
            .TAG_BITS (TAG_BITS),
            .DATA_W   (DATA_W)
        ) u_way (
            .clk      (clk),
            .rst      (rst),
            .index    (index),
            .cmp_tag  (req_tag),
            .tag      (way_tag[w]),
            .data     (way_data[w]),
            .valid    (way_valid[w]),
            .dirty    (way_dirty[w]),
            .hit      (way_hit[w]),
            .we       (way_we[w]),
            .wr_tag   (wr_tag),
            .wr_data  (wr_data),
            .wr_dirty (wr_dirty)
        );
    end

    // Victim is the lowest-numbered invalid way, otherwise the set's LRU way.
    always_comb begin
        hit_way   = 1'b0;
        alloc_way = lru_q[index];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (way_hit[w])    hit_way   = w[0];
            if (!way_valid[w]) alloc_way = w[0];
        end
    end

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        accept       = 1'b0;
        resp_set     = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mru_en       = 1'b0;
        mru_way      = victim_q;
        way_we       = '0;
        wr_tag       = req_tag;
        wr_data      = req_wdata_q;
        wr_dirty     = 1'b1;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
`ifdef CACHE_FLUSH_EN
        flush_step   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef CACHE_FLUSH_EN
                if (flush_req) state_d = StFlush;
                else
`endif
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (|way_hit) begin
                    mru_en   = 1'b1;
                    mru_way  = hit_way;
                    resp_set = 1'b1;
                    state_d  = StIdle;
                    if (req_we_q) way_we[hit_way] = 1'b1;
                    else          resp_rdata_d    = way_data[hit_way];
                end else begin
                    victim_d = alloc_way;
                    if (way_valid[alloc_way] && way_dirty[alloc_way]) begin
                        state_d = StWb;
                    end else if (req_we_q) begin
                        way_we[alloc_way] = 1'b1;
                        mru_en   = 1'b1;
                        mru_way  = alloc_way;
                        resp_set = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StWb: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {way_tag[victim_q], index};
                mem_wdata = way_data[victim_q];
                if (mem_ack) begin
                    if (req_we_q) begin
                        way_we[victim_q] = 1'b1;
                        mru_en   = 1'b1;
                        resp_set = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        state_d = StFill;
                    end
                end
            end
            StFill: begin
                mem_req  = 1'b1;
                mem_addr = req_addr_q;
                if (mem_ack) begin
                    way_we[victim_q] = 1'b1;
                    wr_data      = mem_rdata;
                    wr_dirty     = 1'b0;
                    mru_en       = 1'b1;
                    resp_set     = 1'b1;
                    resp_rdata_d = mem_rdata;
                    state_d      = StIdle;
                end
            end
`ifdef CACHE_FLUSH_EN
            StFlush: begin
                if (way_valid[flush_way_q] && way_dirty[flush_way_q]) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = {way_tag[flush_way_q], flush_set_q};
                    mem_wdata = way_data[flush_way_q];
                    if (mem_ack) begin
                        // Rewrite the line unchanged except for the dirty bit.
                        way_we[flush_way_q] = 1'b1;
                        wr_tag     = way_tag[flush_way_q];
                        wr_data    = way_data[flush_way_q];
                        wr_dirty   = 1'b0;
                        flush_step = 1'b1;
                    end
                end else begin
                    flush_step = 1'b1;
                end
                if (flush_step && flush_last) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            victim_q     <= 1'b0;
            lru_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            resp_valid_q <= resp_set;
            resp_rdata_q <= resp_rdata_d;
            if (accept) begin
                req_we_q    <= req_we;
                req_addr_q  <= req_addr;
                req_wdata_q <= req_wdata;
            end
            if (mru_en) lru_q[index] <= (WAYS > 1) ? ~mru_way : 1'b0;
        end
    end

`ifdef CACHE_FLUSH_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_set_q  <= '0;
            flush_way_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= flush_step && flush_last;
            if (flush_step) begin
                if (flush_way_q == 1'(WAYS - 1)) begin
                    flush_way_q <= 1'b0;
                    flush_set_q <= flush_set_q + 1'b1;
                end else begin
                    flush_way_q <= flush_way_q + 1'b1;
                end
            end
        end
    end
`endif

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: doc/assoc_wb_cache.md
Name: assoc_wb_cache

Overview:
- Parametrised set-associative, write-back, write-allocate data cache between the CPU memory stage and the memory controller; successor to the single-cycle direct-mapped cache.
- Adds configurable depth/ways/widths, LRU replacement, and a request/acknowledge miss engine.
- The engine writes back dirty victims and refills from memory itself instead of exporting writeback hints.
- One word per line.

Parameters:
- ADDR_W, 16, address width in words.
- DATA_W, 16, data word width.
- INDEX_W, 10, set index width; sets = 2^INDEX_W; index = addr[INDEX_W-1:0], tag = addr[ADDR_W-1:INDEX_W].
- WAYS, 2, associativity; legal values 1 or 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  CPU request present.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- req_ready  out  1  cache can accept a request this cycle.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  read data, valid with resp_valid.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = writeback, 0 = refill read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  writeback data.
- mem_ack  in  1  memory completes the transaction this cycle.
- mem_rdata  in  DATA_W  refill data, valid with mem_ack.

Behaviour:
- Reset (rst=0, async): state IDLE; valid, dirty and LRU bits cleared; all outputs 0 except req_ready=1. Tag/data arrays not reset.
- States: IDLE, LOOKUP, WB, FILL.
- IDLE: req_ready=1. On req_valid: latch the request, go to LOOKUP.
- req_valid while req_ready=0: ignored; the CPU holds the request.
- LOOKUP: compare the tag in all valid ways.
  - Hit: read returns the way data; write updates data and sets dirty. Mark the way MRU. Next cycle resp_valid=1; go to IDLE.
  - Hit latency: 2 cycles from the accept edge to the resp_valid cycle.
- Miss victim: lowest-numbered invalid way, else the LRU way (LRU bit per set; WAYS=1 always way 0).
- Victim valid and dirty: go to WB.
- Victim clean or invalid:
  - Read: go to FILL.
  - Write: install tag/data with dirty=1 and valid=1, mark MRU, respond next cycle; no memory traffic.
- WB: mem_req=1, mem_we=1, mem_addr = {victim tag, index}, mem_wdata = victim data.
  - Signals stay stable until mem_ack is sampled high; mem_req drops the cycle after.
  - A write miss then installs as above and responds; a read miss goes to FILL.
- FILL: mem_req=1, mem_we=0, mem_addr = req_addr.
  - On mem_ack: install mem_rdata with dirty=0 and valid=1, mark MRU, pulse resp_valid with resp_rdata=mem_rdata, go to IDLE.
- mem_ack is legal in the first cycle mem_req is high (single-cycle memory). mem_ack while mem_req=0 is ignored.
- resp_valid lasts exactly one cycle; resp_rdata holds its value until the next response.
- Back-to-back requests: the next request may be accepted in the resp_valid cycle. The cache then sees the just-updated state (read-after-write to the same address returns new data).
- Reset mid-transaction: mem_req falls immediately. The in-flight request and all dirty data are discarded; the CPU reissues.

Optional Feature:
- Macro: CACHE_FLUSH_EN.
- Defined: adds ports flush_req (in, 1) and flush_done (out, 1), and state FLUSH.
  - flush_req is sampled only in IDLE and wins over req_valid.
  - FLUSH walks sets 0..2^INDEX_W-1 and, within each set, ways 0..WAYS-1. Each valid dirty line gets a WB-style memory write, then its dirty bit is cleared (valid kept). Clean lines cost 1 cycle.
  - req_ready=0 throughout; flush_done pulses one cycle on return to IDLE.
- Undefined: no ports, no FLUSH state, identical behaviour otherwise.

Decomposition:
- Shared package cache_pkg: state encodings, TAG_W = ADDR_W-INDEX_W, and index/tag extraction constants.
- One sub-module, cache_way: per-way tag/data arrays plus valid/dirty vectors.
  - Combinational read by index; synchronous write port; hit output.
  - Instantiated WAYS times. The top holds the FSM, LRU and memory interface.

Test Plan:
- Reset, read 0x0123 -> mem read at 0x0123; memory returns 0xBEEF with ack after 3 cycles -> resp_rdata=0xBEEF. Reread 0x0123 -> hit, no mem_req, resp 2 cycles after accept.
- Write 0x0040=0xAAAA on empty cache -> no mem traffic, resp_valid after 2 cycles. Read 0x0040 -> 0xAAAA from a hit.
- Fill 0x0123, write 0x0123=0x1111, read 0x0523, read 0x0923 -> mem write at 0x0123 with 0x1111, then mem read at 0x0923; 0x0523 remains a hit.
- mem_ack held high constantly -> each WB/FILL completes in 1 cycle with correct data and no duplicate transactions.
- Pull rst low during WB -> mem_req=0 in the same cycle; after release, reads of previously cached addresses all miss.
- (CACHE_FLUSH_EN) Dirty lines at 0x0010 and 0x0200 -> exactly two mem writes, 0x0010 then 0x0200, then a flush_done pulse; evicting either line later causes no writeback.
